spi_param_bank: RTL

- System-clock-domain register bank directly downstream of the SPI slave controller.
- Captures each completed SPI write (7-bit address, 32-bit data, valid flag) into per-effect-module shadow registers.
- Drives the 32-bit readback word that the controller shifts out on MISO.
- Commits shadow registers to the active parameter outputs atomically on the next audio sample tick, so effect modules never see a half-updated parameter set.

---
 rtl/spi_param_bank_pkg.sv | 54 +++++
 rtl/spi_param_slot.sv | 75 +++++++
 rtl/spi_param_bank.sv | 136 +++++++++++++
 3 files changed

// File: rtl/spi_param_bank_pkg.sv
// Shared constants and address decode for the SPI parameter bank.
//
// Address layout (7 bits): [6:3] register index, [2:0] module select.
// Module select 3'b111 is the control space (CTRL / STATUS / ID).
package spi_param_bank_pkg;

    localparam int unsigned MOD_SEL_W     = 3;
    localparam int unsigned REG_IDX_W     = 4;
    localparam int unsigned ADDR_MOD_LSB  = 0;
    localparam int unsigned ADDR_MOD_MSB  = 2;
    localparam int unsigned ADDR_IDX_LSB  = 3;
    localparam int unsigned ADDR_IDX_MSB  = 6;

    localparam logic [MOD_SEL_W-1:0] CTRL_MODULE_SEL = 3'b111;
    localparam logic [REG_IDX_W-1:0] REG_CTRL        = 4'd0;
    localparam logic [REG_IDX_W-1:0] REG_STATUS      = 4'd1;
    localparam logic [REG_IDX_W-1:0] REG_ID          = 4'd2;

    localparam int unsigned CTRL_COMMIT_BIT  = 0;
    localparam int unsigned CTRL_CLR_ERR_BIT = 1;

    localparam logic [31:0] BANK_ID_DEFAULT = 32'h5045_0001;

    typedef enum logic [2:0] {
        ADDR_MODULE,
        ADDR_CTRL,
        ADDR_STATUS,
        ADDR_ID,
        ADDR_UNMAPPED
    } addr_kind_e;

    // Control space is checked first so it can never alias a module slot.
    function automatic addr_kind_e classify_addr(
        input logic [MOD_SEL_W-1:0] mod_sel,
        input logic [REG_IDX_W-1:0] reg_idx,
        input int unsigned          num_modules,
        input int unsigned          num_regs
    );
        addr_kind_e kind;
        kind = ADDR_UNMAPPED;
        if (mod_sel == CTRL_MODULE_SEL) begin
            case (reg_idx)
                REG_CTRL:   kind = ADDR_CTRL;
                REG_STATUS: kind = ADDR_STATUS;
                REG_ID:     kind = ADDR_ID;
                default:    kind = ADDR_UNMAPPED;
            endcase
        end else if ((32'(mod_sel) < num_modules) && (32'(reg_idx) < num_regs)) begin
            kind = ADDR_MODULE;
        end
        return kind;
    endfunction

endpackage

// File: rtl/spi_param_slot.sv
// One effect module's parameter storage: NUM_REGS shadow registers written
// from SPI, NUM_REGS active registers loaded from shadow on commit, and a
// dirty bit marking un-committed shadow changes.
//
// Ports:
//   i_CLK, i_RST   clock, synchronous active-high reset
//   i_WR_EN        write shadow[i_WR_IDX] = i_WR_DATA this cycle
//   i_COMMIT       commit cycle: copy shadow -> active if dirty
//   i_RD_IDX       shadow readback select (combinational o_RD_DATA)
//   o_ACTIVE       active registers, flattened, register r at word r
//   o_DIRTY        shadow differs from last commit
//   o_UPDATE       one-cycle pulse after a commit that changed active
module spi_param_slot #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned IDX_W      = 3
) (
    input  logic                           i_CLK,
    input  logic                           i_RST,
    input  logic                           i_WR_EN,
    input  logic [IDX_W-1:0]               i_WR_IDX,
    input  logic [DATA_WIDTH-1:0]          i_WR_DATA,
    input  logic                           i_COMMIT,
    input  logic [IDX_W-1:0]               i_RD_IDX,
    output logic [DATA_WIDTH-1:0]          o_RD_DATA,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_ACTIVE,
    output logic                           o_DIRTY,
    output logic                           o_UPDATE
);

    logic [DATA_WIDTH-1:0] r_shadow [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_active [NUM_REGS];
    logic                  r_dirty;
    logic                  r_update;
    logic                  w_do_copy;

    assign w_do_copy = i_COMMIT & r_dirty;

    // The copy reads shadow before this cycle's write lands, and a write on
    // the commit cycle keeps the module dirty so it goes out next commit.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_dirty  <= 1'b0;
            r_update <= 1'b0;
        end else begin
            if (w_do_copy) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
            if (i_WR_EN) begin
                r_shadow[i_WR_IDX] <= i_WR_DATA;
            end
            if (i_WR_EN) begin
                r_dirty <= 1'b1;
            end else if (i_COMMIT) begin
                r_dirty <= 1'b0;
            end
            r_update <= w_do_copy;
        end
    end

    assign o_RD_DATA = r_shadow[i_RD_IDX];
    assign o_DIRTY   = r_dirty;
    assign o_UPDATE  = r_update;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign o_ACTIVE[g*DATA_WIDTH +: DATA_WIDTH] = r_active[g];
    end

endmodule

// File: rtl/spi_param_bank.sv
// SPI-facing parameter register bank. Captures SPI writes into per-module
// shadow registers, serves the MISO readback word, and commits shadow to
// active outputs atomically on the first audio sample tick after a CTRL
// commit request.
//
// Ports:
//   i_CLK, i_RST     system clock, synchronous active-high reset
//   i_ADDR           SPI address: [6:3] register index, [2:0] module select
//   i_DATA_IN        SPI write data
//   i_DOUT_VALID     write valid level; its rising edge is one write
//   i_SAMPLE_TICK    one-cycle pulse per audio sample
//   o_DATA_OUT       registered readback for the current i_ADDR
//   o_PARAMS         active registers; module m reg r at word m*NUM_REGS+r
//   o_UPDATE         per-module pulse after its active registers changed
//   o_ERROR          sticky unmapped-write flag, cleared via CTRL bit 1
module spi_param_bank
    import spi_param_bank_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           ADDR_WIDTH  = 7,
    parameter int unsigned           NUM_MODULES = 4,
    parameter int unsigned           NUM_REGS    = 8,
    parameter logic [DATA_WIDTH-1:0] BANK_ID     = BANK_ID_DEFAULT
) (
    input  logic                                       i_CLK,
    input  logic                                       i_RST,
    input  logic [ADDR_WIDTH-1:0]                      i_ADDR,
    input  logic [DATA_WIDTH-1:0]                      i_DATA_IN,
    input  logic                                       i_DOUT_VALID,
    input  logic                                       i_SAMPLE_TICK,
    output logic [DATA_WIDTH-1:0]                      o_DATA_OUT,
    output logic [NUM_MODULES*NUM_REGS*DATA_WIDTH-1:0] o_PARAMS,
    output logic [NUM_MODULES-1:0]                     o_UPDATE,
    output logic                                       o_ERROR
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                  r_valid_prev;
    logic                  r_commit_pending;
    logic                  r_error;
    logic [DATA_WIDTH-1:0] r_data_out;

    logic [MOD_SEL_W-1:0]  w_mod;
    logic [REG_IDX_W-1:0]  w_idx;
    logic [IDX_W-1:0]      w_idx_lo;
    addr_kind_e            w_kind;
    logic                  w_write;
    logic                  w_mod_wr;
    logic                  w_ctrl_wr;
    logic                  w_unmapped_wr;
    logic                  w_commit;
    logic [DATA_WIDTH-1:0] w_slot_rd [NUM_MODULES];
    logic [NUM_MODULES-1:0] w_dirty;
    logic [DATA_WIDTH-1:0] w_rd_next;

    assign w_mod    = i_ADDR[ADDR_MOD_MSB:ADDR_MOD_LSB];
    assign w_idx    = i_ADDR[ADDR_IDX_MSB:ADDR_IDX_LSB];
    assign w_idx_lo = w_idx[IDX_W-1:0];
    assign w_kind   = classify_addr(w_mod, w_idx, NUM_MODULES, NUM_REGS);

    assign w_write       = i_DOUT_VALID & ~r_valid_prev;
    assign w_mod_wr      = w_write && (w_kind == ADDR_MODULE);
    assign w_ctrl_wr     = w_write && (w_kind == ADDR_CTRL);
    assign w_unmapped_wr = w_write && (w_kind != ADDR_MODULE) && (w_kind != ADDR_CTRL);

    // Pending is sampled before this cycle's CTRL write, so a tick on the
    // request edge itself does not commit.
    assign w_commit = i_SAMPLE_TICK & r_commit_pending;

    for (genvar m = 0; m < NUM_MODULES; m++) begin : g_slot
        spi_param_slot #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_REGS   (NUM_REGS),
            .IDX_W      (IDX_W)
        ) u_slot (
            .i_CLK     (i_CLK),
            .i_RST     (i_RST),
            .i_WR_EN   (w_mod_wr && (w_mod == MOD_SEL_W'(m))),
            .i_WR_IDX  (w_idx_lo),
            .i_WR_DATA (i_DATA_IN),
            .i_COMMIT  (w_commit),
            .i_RD_IDX  (w_idx_lo),
            .o_RD_DATA (w_slot_rd[m]),
            .o_ACTIVE  (o_PARAMS[m*NUM_REGS*DATA_WIDTH +: NUM_REGS*DATA_WIDTH]),
            .o_DIRTY   (w_dirty[m]),
            .o_UPDATE  (o_UPDATE[m])
        );
    end

    always_comb begin
        w_rd_next = '0;
        case (w_kind)
            ADDR_MODULE: begin
                for (int unsigned m = 0; m < NUM_MODULES; m++) begin
                    if (32'(w_mod) == m) begin
                        w_rd_next = w_slot_rd[m];
                    end
                end
            end
            ADDR_STATUS: w_rd_next = {{(DATA_WIDTH-3){1'b0}}, r_commit_pending, r_error, |w_dirty};
            ADDR_ID:     w_rd_next = BANK_ID;
            default:     w_rd_next = '0;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_valid_prev     <= 1'b0;
            r_commit_pending <= 1'b0;
            r_error          <= 1'b0;
            r_data_out       <= '0;
        end else begin
            r_valid_prev <= i_DOUT_VALID;
            r_data_out   <= w_rd_next;

            // A commit consumes any request arriving on the same cycle.
            if (w_commit) begin
                r_commit_pending <= 1'b0;
            end else if (w_ctrl_wr && i_DATA_IN[CTRL_COMMIT_BIT]) begin
                r_commit_pending <= 1'b1;
            end

            // Set has priority over clear.
            if (w_unmapped_wr) begin
                r_error <= 1'b1;
            end else if (w_ctrl_wr && i_DATA_IN[CTRL_CLR_ERR_BIT]) begin
                r_error <= 1'b0;
            end
        end
    end

    assign o_DATA_OUT = r_data_out;
    assign o_ERROR    = r_error;

endmodule
